// File: rtl/temporizador_fase.sv
// Phase timer: counts a loaded number of seconds down to zero, with pause, cancel and restart.
// Optional TEMPORIZADOR_AVISO_EN adds parameter AVISO_S and a registered near-expiry output aviso.
module temporizador_fase #(
    parameter int TICKS     = 50000000,
    parameter int NP        = 26,
    parameter int TEMPO_MAX = 99
`ifdef TEMPORIZADOR_AVISO_EN
    ,
    parameter int AVISO_S   = 10
`endif
) (
    input  logic       clock,
    input  logic       zera_n,
    input  logic       iniciar,
    input  logic       pausar,
    input  logic       cancelar,
    input  logic [7:0] tempo,
    output logic [7:0] restante,
    output logic       tick,
    output logic       esgotado,
    output logic       ativo,
    output logic [1:0] estado
`ifdef TEMPORIZADOR_AVISO_EN
    ,
    output logic       aviso
`endif
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        ESGOTADO = 2'b11
    } estado_t;

    localparam logic [NP-1:0] PRESC_FIM = NP'(TICKS - 1);
    localparam logic [NP-1:0] PRESC_UM  = NP'(1);
    localparam logic [7:0]    TMAX      = 8'(TEMPO_MAX);

    function automatic logic [7:0] sat_tempo(input logic [7:0] t);
        return (t > TMAX) ? TMAX : t;
    endfunction

    estado_t       estado_q, estado_d;
    logic [NP-1:0] presc_q, presc_d;
    logic [7:0]    restante_q, restante_d;
    logic          tick_q, tick_d;
    logic          esgotado_q, esgotado_d;
`ifdef TEMPORIZADOR_AVISO_EN
    localparam logic [7:0] AVISO_LIM = 8'(AVISO_S);
    logic          aviso_q, aviso_d;
`endif

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            estado_q   <= OCIOSO;
            presc_q    <= '0;
            restante_q <= '0;
            tick_q     <= 1'b0;
            esgotado_q <= 1'b0;
`ifdef TEMPORIZADOR_AVISO_EN
            aviso_q    <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            presc_q    <= presc_d;
            restante_q <= restante_d;
            tick_q     <= tick_d;
            esgotado_q <= esgotado_d;
`ifdef TEMPORIZADOR_AVISO_EN
            aviso_q    <= aviso_d;
`endif
        end
    end

    always_comb begin
        estado_d   = estado_q;
        presc_d    = presc_q;
        restante_d = restante_q;
        tick_d     = 1'b0;
        esgotado_d = 1'b0;
        if (cancelar) begin
            estado_d   = OCIOSO;
            presc_d    = '0;
            restante_d = '0;
        end else if (iniciar) begin
            // A zero duration is rejected outright: the whole block holds for this edge.
            if (tempo != 8'd0) begin
                estado_d   = CONTANDO;
                presc_d    = '0;
                restante_d = sat_tempo(tempo);
            end
        end else begin
            case (estado_q)
                CONTANDO: begin
                    if (pausar) begin
                        estado_d = PAUSADO;
                    end else if (presc_q == PRESC_FIM) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (restante_q <= 8'd1) begin
                            restante_d = '0;
                            estado_d   = ESGOTADO;
                            esgotado_d = 1'b1;
                        end else begin
                            restante_d = restante_q - 8'd1;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_UM;
                    end
                end
                PAUSADO: begin
                    if (!pausar) estado_d = CONTANDO;
                end
                default: begin
                    presc_d = '0;
                end
            endcase
        end
    end

`ifdef TEMPORIZADOR_AVISO_EN
    // Computed from next-state values so aviso lines up with the restante it describes.
    always_comb begin
        aviso_d = ((estado_d == CONTANDO) || (estado_d == PAUSADO)) &&
                  (restante_d != 8'd0) && (restante_d <= AVISO_LIM);
    end
    assign aviso = aviso_q;
`endif

    assign restante = restante_q;
    assign tick     = tick_q;
    assign esgotado = esgotado_q;
    assign estado   = estado_q;
    assign ativo    = (estado_q == CONTANDO) || (estado_q == PAUSADO);

endmodule

// File: tb/tb_temporizador_fase.sv
// Directed bench for temporizador_fase with TICKS=4 (one "second" = 4 clocks).
module tb_temporizador_fase;

    logic       clock = 1'b0;
    logic       zera_n;
    logic       iniciar, pausar, cancelar;
    logic [7:0] tempo;
    logic [7:0] restante;
    logic       tick, esgotado, ativo;
    logic [1:0] estado;
`ifdef TEMPORIZADOR_AVISO_EN
    logic       aviso;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    temporizador_fase #(
        .TICKS(4), .NP(2), .TEMPO_MAX(99)
`ifdef TEMPORIZADOR_AVISO_EN
        , .AVISO_S(2)
`endif
    ) dut (
        .clock(clock), .zera_n(zera_n), .iniciar(iniciar), .pausar(pausar),
        .cancelar(cancelar), .tempo(tempo), .restante(restante), .tick(tick),
        .esgotado(esgotado), .ativo(ativo), .estado(estado)
`ifdef TEMPORIZADOR_AVISO_EN
        , .aviso(aviso)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start(input logic [7:0] t);
        iniciar = 1'b1;
        tempo   = t;
        step();
        iniciar = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int e_est, input int e_rest,
                           input int e_tick, input int e_esg);
        chk({tag, ".estado"}, estado, e_est);
        chk({tag, ".restante"}, restante, e_rest);
        chk({tag, ".tick"}, tick, e_tick);
        chk({tag, ".esgotado"}, esgotado, e_esg);
    endtask

    initial begin
        zera_n = 1'b0; iniciar = 1'b0; pausar = 1'b0; cancelar = 1'b0; tempo = 8'd0;
        #12;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.ativo", ativo, 0);
        zera_n = 1'b1;
        step();

        // Basic 3-second phase
        start(8'd3);
        chk_out("start3", 1, 3, 0, 0);
        chk("start3.ativo", ativo, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_out($sformatf("run3.c%0d", k), (k == 12) ? 3 : 1,
                    (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0,
                    (k % 4 == 0) ? 1 : 0, (k == 12) ? 1 : 0);
        end
        step();
        chk_out("after_exp", 3, 0, 0, 0);
        chk("after_exp.ativo", ativo, 0);
        pausar = 1'b1;
        step(2);
        chk_out("esg_pause", 3, 0, 0, 0);
        pausar = 1'b0;

        // Restart from ESGOTADO, then iniciar+cancelar together
        start(8'd7);
        chk_out("restart7", 1, 7, 0, 0);
        iniciar = 1'b1; cancelar = 1'b1; tempo = 8'd9;
        step();
        iniciar = 1'b0; cancelar = 1'b0;
        chk_out("ini_cancel", 0, 0, 0, 0);

        // Saturation and zero duration
        start(8'd200);
        chk_out("sat200", 1, 99, 0, 0);
        cancelar = 1'b1;
        step();
        cancelar = 1'b0;
        chk_out("cancel", 0, 0, 0, 0);
        start(8'd0);
        chk_out("tempo0", 0, 0, 0, 0);

        // iniciar overrides pausar
        pausar = 1'b1;
        start(8'd2);
        pausar = 1'b0;
        chk_out("ini_over_pause", 1, 2, 0, 0);

        // Pause with prescaler at 2 held for 10 edges
        start(8'd5);
        step(2);
        pausar = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_out($sformatf("pause.c%0d", k), 2, 5, 0, 0);
        end
        chk("pause.ativo", ativo, 1);
        pausar = 1'b0;
        step();
        chk_out("resume0", 1, 5, 0, 0);
        step();
        chk_out("resume1", 1, 5, 0, 0);
        step();
        chk_out("resume2", 1, 4, 1, 0);

        // Asynchronous reset mid-cycle right after a tick
        start(8'd3);
        step(4);
        chk_out("pre_rst", 1, 2, 1, 0);
        #2 zera_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        chk("async_rst.ativo", ativo, 0);
        #3 zera_n = 1'b1;
        step(2);
        chk_out("post_rst", 0, 0, 0, 0);

`ifdef TEMPORIZADOR_AVISO_EN
        start(8'd4);
        chk("aviso.r4", aviso, 0);
        step(4);
        chk("aviso.r3", aviso, 0);
        step(4);
        chk("aviso.r2", aviso, 1);
        chk("aviso.r2.rest", restante, 2);
        step(4);
        chk("aviso.r1", aviso, 1);
        step(4);
        chk("aviso.exp", aviso, 0);
        chk("aviso.exp.est", estado, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
